// File: rtl/seq_issue_ctrl.sv
// seq_issue_ctrl: instruction issue controller for the sequencer.
//
// Holds a short program that is appended one instruction at a time from
// the board switches. The program is issued one instruction per step pulse,
// or continuously while run is held high. Send instructions (opcode OP_SEND)
// are paced against the UART busy line:
//   - wait for the UART to go idle;
//   - issue the send;
//   - wait for busy to rise, then fall again.
// If busy never rises within TX_TIMEOUT cycles, a sticky error is raised and
// the program moves on.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_load_inst, i_load_valid   append an instruction (IDLE/HALT, not full)
//   i_clear                     empty the program, pc <- 0, clear tx error
//   i_rewind                    pc <- 0, program kept
//   i_step, i_run               issue one / issue continuously
//   i_tx_busy                   UART transmitter busy
//   o_inst, o_inst_valid        registered instruction and issue strobe
//   o_pc, o_prog_len            next index to issue, number of loaded entries
//   o_full, o_done, o_tx_err    buffer full, program finished, send timeout
module seq_issue_ctrl #(
    parameter int                  INST_WIDTH = 8,
    parameter int                  OP_WIDTH   = 2,
    parameter logic [OP_WIDTH-1:0] OP_SEND    = 2'b11,
    parameter int                  PROG_DEPTH = 16,
    parameter int                  ADDR_WIDTH = 4,
    parameter int                  TX_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] i_load_inst,
    input  logic                  i_load_valid,
    input  logic                  i_clear,
    input  logic                  i_rewind,
    input  logic                  i_step,
    input  logic                  i_run,
    input  logic                  i_tx_busy,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_inst_valid,
    output logic [ADDR_WIDTH:0]   o_pc,
    output logic [ADDR_WIDTH:0]   o_prog_len,
    output logic                  o_full,
    output logic                  o_done,
    output logic                  o_tx_err
);

    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, TXWAIT, SEND, BUSYWAIT, DRAIN, ADV, HALT
    } state_t;

    state_t                  state;
    logic [INST_WIDTH-1:0]   mem [PROG_DEPTH];
    logic [ADDR_WIDTH:0]     pc;
    logic [ADDR_WIDTH:0]     prog_len;
    logic [CNT_W-1:0]        tmo;
    logic                    load_ok;
    logic                    has_next;
    logic                    go;
    logic                    is_send;
    logic [INST_WIDTH-1:0]   cur_inst;

    assign o_full     = (prog_len == (ADDR_WIDTH+1)'(PROG_DEPTH));
    assign o_pc       = pc;
    assign o_prog_len = prog_len;

    // A clear in the same cycle wins over an append.
    assign load_ok  = i_load_valid && !o_full && !i_clear &&
                      (state == IDLE || state == HALT);
    assign has_next = (pc < prog_len);
    assign go       = (i_step || i_run) && has_next;
    assign cur_inst = mem[pc[ADDR_WIDTH-1:0]];
    assign is_send  = (cur_inst[INST_WIDTH-1 -: OP_WIDTH] == OP_SEND);

    // Program buffer has no reset; contents are only read below prog_len.
    always_ff @(posedge clk) begin
        if (load_ok)
            mem[prog_len[ADDR_WIDTH-1:0]] <= i_load_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= '0;
            prog_len     <= '0;
            tmo          <= '0;
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_done       <= 1'b0;
            o_tx_err     <= 1'b0;
        end else begin
            o_inst       <= cur_inst;
            o_inst_valid <= 1'b0;
            o_done       <= 1'b0;
            if (load_ok)
                prog_len <= prog_len + 1'b1;

            if (i_clear) begin
                prog_len <= '0;
                pc       <= '0;
                o_tx_err <= 1'b0;
                state    <= IDLE;
            end else if (i_rewind) begin
                pc    <= '0;
                state <= IDLE;
            end else begin
                // Valid and done are set on the transition into the state
                // that owns them, so they line up with that state's cycle.
                case (state)
                    IDLE: begin
                        if (go) begin
                            if (is_send) begin
                                state <= TXWAIT;
                            end else begin
                                state        <= ISSUE;
                                o_inst_valid <= 1'b1;
                            end
                        end else if (!has_next && prog_len != '0 && !load_ok) begin
                            // A same-cycle append keeps us in IDLE instead of
                            // bouncing through HALT.
                            state  <= HALT;
                            o_done <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        pc    <= pc + 1'b1;
                        state <= IDLE;
                    end
                    TXWAIT: begin
                        if (!i_tx_busy) begin
                            state        <= SEND;
                            o_inst_valid <= 1'b1;
                        end
                    end
                    SEND: begin
                        tmo   <= CNT_W'(TX_TIMEOUT);
                        state <= BUSYWAIT;
                    end
                    BUSYWAIT: begin
                        if (i_tx_busy) begin
                            state <= DRAIN;
                        end else if (tmo <= CNT_W'(1)) begin
                            o_tx_err <= 1'b1;
                            state    <= ADV;
                        end else begin
                            tmo <= tmo - 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!i_tx_busy)
                            state <= ADV;
                    end
                    ADV: begin
                        pc    <= pc + 1'b1;
                        state <= IDLE;
                    end
                    HALT: begin
                        if (load_ok || has_next)
                            state <= IDLE;
                        else
                            o_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_issue_ctrl.sv
module tb_seq_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_load_inst = '0;
    logic       i_load_valid = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_rewind = 1'b0;
    logic       i_step = 1'b0;
    logic       i_run = 1'b0;
    logic       i_tx_busy = 1'b0;
    logic [7:0] o_inst;
    logic       o_inst_valid;
    logic [4:0] o_pc;
    logic [4:0] o_prog_len;
    logic       o_full;
    logic       o_done;
    logic       o_tx_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic       chk_gap = 1'b0;
    int         cyc = 0;
    int         last_vcyc;

    seq_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .i_load_inst(i_load_inst), .i_load_valid(i_load_valid),
        .i_clear(i_clear), .i_rewind(i_rewind),
        .i_step(i_step), .i_run(i_run), .i_tx_busy(i_tx_busy),
        .o_inst(o_inst), .o_inst_valid(o_inst_valid),
        .o_pc(o_pc), .o_prog_len(o_prog_len),
        .o_full(o_full), .o_done(o_done), .o_tx_err(o_tx_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every issue strobe pops the scoreboard.
    always @(negedge clk) begin
        if (!chk_gap) last_vcyc = -1;
        if (!rst && o_inst_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {24'h0, o_inst}, 32'hFFFF_FFFF);
            end else begin
                check("issued_inst", {24'h0, o_inst}, {24'h0, exp_q.pop_front()});
            end
            if (chk_gap) begin
                if (last_vcyc >= 0) check("run_gap", cyc - last_vcyc, 2);
                last_vcyc = cyc;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] v);
        i_load_inst  = v;
        i_load_valid = 1'b1;
        tick();
        i_load_valid = 1'b0;
    endtask

    task automatic step();
        i_step = 1'b1;
        tick();
        i_step = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #1;
        check("rst_valid", o_inst_valid, 0);
        check("rst_pc", o_pc, 0);
        check("rst_len", o_prog_len, 0);
        check("rst_done", o_done, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Empty program: step/run ignored, not done.
        step();
        tick(2);
        check("empty_done", o_done, 0);
        check("empty_pc", o_pc, 0);

        // Three plain instructions, stepped.
        load(8'h05); load(8'h16); load(8'h27);
        check("len3", o_prog_len, 3);
        exp_q.push_back(8'h05); step(); tick(5);
        exp_q.push_back(8'h16); step(); tick(5);
        exp_q.push_back(8'h27); step(); tick(5);
        check("done_after3", o_done, 1);
        check("pc3", o_pc, 3);
        step(); tick(4);
        check("done_held", o_done, 1);

        // Send paced against a busy UART.
        pulse_clear();
        load(8'hC0);
        i_tx_busy = 1'b1;
        exp_q.push_back(8'hC0);
        step(); tick(5);
        check("txwait_pc", o_pc, 0);
        i_tx_busy = 1'b0;
        tick();
        check("send_valid", o_inst_valid, 1);
        i_tx_busy = 1'b1;
        tick(10);
        check("drain_pc", o_pc, 0);
        i_tx_busy = 1'b0;
        tick(4);
        check("send_pc", o_pc, 1);
        check("send_err", o_tx_err, 0);
        check("send_done", o_done, 1);

        // Send whose busy never rises -> timeout.
        load(8'hC1);
        exp_q.push_back(8'hC1);
        step();
        tick();
        check("to_valid", o_inst_valid, 1);
        tick(10);
        check("to_err_early", o_tx_err, 0);
        tick(10);
        check("to_err", o_tx_err, 1);
        check("to_pc", o_pc, 2);
        i_rewind = 1'b1; tick(); i_rewind = 1'b0;
        check("rewind_err", o_tx_err, 1);
        check("rewind_pc", o_pc, 0);
        check("rewind_len", o_prog_len, 2);
        pulse_clear();
        check("clear_err", o_tx_err, 0);
        check("clear_len", o_prog_len, 0);

        // Fill the buffer; 17th load ignored; run it all.
        for (int i = 0; i < 16; i++) load(8'h10 + 8'(i));
        check("full", o_full, 1);
        check("len16", o_prog_len, 16);
        load(8'h3F);
        check("len16_after17", o_prog_len, 16);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
        chk_gap = 1'b1;
        i_run = 1'b1;
        n = 0;
        while (!o_done && n < 100) begin tick(); n++; end
        i_run = 1'b0;
        chk_gap = 1'b0;
        check("run_done", o_done, 1);
        check("run_pc", o_pc, 16);
        check("run_left", exp_q.size(), 0);

        // Clear during DRAIN drops the send.
        pulse_clear();
        load(8'hC2);
        exp_q.push_back(8'hC2);
        step();
        tick();
        check("drain_send_valid", o_inst_valid, 1);
        i_tx_busy = 1'b1;
        tick(3);
        pulse_clear();
        check("clr_valid", o_inst_valid, 0);
        check("clr_pc", o_pc, 0);
        check("clr_len", o_prog_len, 0);
        tick(3);
        i_tx_busy = 1'b0;

        // Load and step together with an empty program: load only.
        i_load_inst = 8'h05; i_load_valid = 1'b1; i_step = 1'b1;
        tick();
        i_load_valid = 1'b0; i_step = 1'b0;
        check("ls_len", o_prog_len, 1);
        check("ls_valid", o_inst_valid, 0);
        tick(3);
        check("ls_pc", o_pc, 0);

        // Async reset in the middle of a run.
        exp_q.push_back(8'h05);
        i_run = 1'b1;
        tick();
        check("pre_rst_valid", o_inst_valid, 1);
        #6;
        rst = 1'b1;
        #1;
        check("arst_valid", o_inst_valid, 0);
        check("arst_inst", o_inst, 0);
        check("arst_pc", o_pc, 0);
        check("arst_len", o_prog_len, 0);
        check("arst_done", o_done, 0);
        check("arst_err", o_tx_err, 0);
        check("arst_full", o_full, 0);
        i_run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_issue_ctrl.md
Name: seq_issue_ctrl

Overview:
Instruction issue controller that sits in front of the sequencer's instruction interface (i_inst/i_inst_valid) and the UART busy line. It buffers a short program loaded from the board switches and issues it one instruction at a time, on a step pulse or continuously in run mode. It paces send instructions against the UART so that no transmit is ever issued while the UART is busy.

Parameters:
INST_WIDTH, 8, instruction width (op field in the top OP_WIDTH bits)
OP_WIDTH, 2, opcode field width
OP_SEND, 2'b11, opcode value of the send instruction
PROG_DEPTH, 16, program buffer entries
ADDR_WIDTH, 4, log2(PROG_DEPTH)
TX_TIMEOUT, 15, cycles to wait for i_tx_busy to rise after a send

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_load_inst  input  INST_WIDTH  instruction to append to the program
i_load_valid  input  1  one-cycle append strobe
i_clear  input  1  one-cycle pulse: empty the program, pc←0
i_rewind  input  1  one-cycle pulse: pc←0, keep the program
i_step  input  1  one-cycle pulse: issue the next instruction
i_run  input  1  level: issue continuously while high
i_tx_busy  input  1  UART busy, from the tx module
o_inst  output  INST_WIDTH  instruction to the sequencer (registered)
o_inst_valid  output  1  one-cycle issue strobe to the sequencer (registered)
o_pc  output  ADDR_WIDTH+1  index of the next instruction to issue
o_prog_len  output  ADDR_WIDTH+1  number of loaded instructions
o_full  output  1  prog_len==PROG_DEPTH
o_done  output  1  high in HALT
o_tx_err  output  1  sticky: a send timed out waiting for busy

Behaviour:
- Reset (async): all outputs 0; pc=0, prog_len=0, state=IDLE; buffer contents don't-care.
- Load: accepted only in IDLE or HALT with !o_full. Write mem[prog_len]←i_load_inst; prog_len++ next cycle. Silently ignored when full or in any other state.
- Start condition: go = i_step | i_run, evaluated only in IDLE and only when pc<prog_len (the pre-load value if a load occurs in the same cycle).
- o_inst is registered mem[pc] in every state. o_inst_valid is high only in ISSUE and SEND.
- FSM:
  - IDLE: on go, if mem[pc][top OP_WIDTH bits]==OP_SEND → TXWAIT, else → ISSUE. If pc==prog_len and prog_len>0 → HALT.
  - ISSUE: o_inst_valid=1 for exactly 1 cycle; pc++; → IDLE. Non-send throughput in run mode is 1 instruction per 2 cycles.
  - TXWAIT: valid=0; wait for i_tx_busy==0, then → SEND.
  - SEND: valid=1 for 1 cycle; load the timeout counter with TX_TIMEOUT; → BUSYWAIT.
  - BUSYWAIT: if i_tx_busy==1 → DRAIN. If the counter reaches 0 first, set o_tx_err and → ADV.
  - DRAIN: wait for i_tx_busy==0, then → ADV.
  - ADV: pc++; → IDLE.
  - HALT: o_done=1. A load moves to IDLE, since pc<prog_len again. Step/run are ignored.
- Step pulses arriving outside IDLE are dropped, not queued.
- Priority every cycle: i_clear > i_rewind > FSM.
  - i_clear from any state: prog_len←0, pc←0, o_tx_err←0, → IDLE, o_inst_valid=0 the next cycle.
  - i_rewind from any state: pc←0, → IDLE; the program and o_tx_err are kept.
  - Either abort mid-send drops the send without incrementing pc.
- prog_len==0: IDLE holds regardless of step/run; o_done=0.
- Loading exactly PROG_DEPTH entries sets o_full and leaves prog_len=16. There is no wrap-around.

Test Plan:
- Reset mid-run with i_run=1 → all outputs 0 within the same cycle; pc=0, prog_len=0.
- Load 3 non-send instructions 0x05,0x16,0x27, then three i_step pulses spaced 5 cycles → exactly three 1-cycle valids with o_inst 0x05,0x16,0x27. Then o_done=1, pc=3; a fourth step produces no valid.
- Load 0xC0 (send), hold i_tx_busy=1, pulse step → no valid while busy. Release busy → valid 1 cycle later. Model busy high for 10 cycles → pc increments only after busy falls; o_tx_err=0.
- Send with i_tx_busy held 0 → valid once, then o_tx_err=1 after 15 cycles; pc advances; a subsequent i_rewind keeps o_tx_err=1 and a subsequent i_clear clears it.
- Load 17 instructions → o_full=1 after the 16th, prog_len=16, 17th ignored. Run mode → 16 valids, 2 cycles apart, then HALT.
- i_clear asserted during DRAIN → valid stays 0, pc=0, prog_len=0. i_load_valid and i_step in the same IDLE cycle with prog_len=0 → load taken, no issue.
